// File: rtl/encoder_velocity_pkg.sv
// Shared types and constants for the encoder velocity block.
package encoder_velocity_pkg;

    localparam int unsigned W_DEFAULT = 32;
    localparam logic [W_DEFAULT-1:0] PERIOD_UNKNOWN = '1;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StRun
    } state_e;

endpackage

// File: rtl/sat_timer.sv
// W-bit saturating up-counter with synchronous clear-to-1; resets to all-ones.
module sat_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = W'(1);
        end else if (value_q != '1) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '1;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/encoder_velocity.sv
// Step period / direction estimator for a quadrature count, with snapshots
// taken on PWM carrier sync strobes.
module encoder_velocity
    import encoder_velocity_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] counter,
    input  logic         pwm_carrier_low,
    input  logic         pwm_carrier_high,
    input  logic [W-1:0] timeout_cycles,
    output logic [W-1:0] period,
    output logic         direction,
    output logic         stopped,
    output logic [W-1:0] period_synced,
    output logic         direction_synced,
    output logic         stopped_synced,
    output logic [W-1:0] delta_synced
);

    localparam logic [W-1:0] PeriodUnknown = {W{1'b1}};

    state_e       state_q, state_d;
    logic [W-1:0] prev_cnt_q, last_sync_cnt_q;
    logic [W-1:0] period_q, period_d;
    logic         direction_q, direction_d;
    logic [W-1:0] period_synced_q, delta_synced_q;
    logic         direction_synced_q, stopped_synced_q;

    logic [W-1:0] cnt_diff;
    logic [W-1:0] gap;
    logic         step, step_dir, sync;

    assign cnt_diff = counter - prev_cnt_q;
    assign step     = (counter != prev_cnt_q);
    // Modulo difference: 0xFFFFFFFF -> 0 yields +1, i.e. an increment.
    assign step_dir = ~cnt_diff[W-1];
    assign sync     = pwm_carrier_low | pwm_carrier_high;

    sat_timer #(
        .W (W)
    ) u_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (step),
        .value (gap)
    );

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        direction_d = direction_q;
        unique case (state_q)
            StIdle: begin
                if (step) begin
                    state_d     = StFirst;
                    direction_d = step_dir;
                    period_d    = PeriodUnknown;
                end
            end
            StFirst, StRun: begin
                // A step in the same clk as a timeout takes priority.
                if (step) begin
                    if (step_dir == direction_q) begin
                        state_d  = StRun;
                        period_d = gap;
                    end else begin
                        state_d     = StFirst;
                        direction_d = step_dir;
                        period_d    = PeriodUnknown;
                    end
                end else if ((timeout_cycles != '0) && (gap >= timeout_cycles)) begin
                    state_d  = StIdle;
                    period_d = PeriodUnknown;
                end
            end
            default: begin
                state_d  = StIdle;
                period_d = PeriodUnknown;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prev_cnt_q  <= '0;
            period_q    <= PeriodUnknown;
            direction_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            prev_cnt_q  <= counter;
            period_q    <= period_d;
            direction_q <= direction_d;
        end
    end

    // Snapshots take the registered outputs, i.e. values before this clk's update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sync_cnt_q    <= '0;
            period_synced_q    <= PeriodUnknown;
            direction_synced_q <= 1'b1;
            stopped_synced_q   <= 1'b1;
            delta_synced_q     <= '0;
        end else if (sync) begin
            last_sync_cnt_q    <= counter;
            period_synced_q    <= period_q;
            direction_synced_q <= direction_q;
            stopped_synced_q   <= (state_q == StIdle);
            delta_synced_q     <= counter - last_sync_cnt_q;
        end
    end

    assign period           = period_q;
    assign direction        = direction_q;
    assign stopped          = (state_q == StIdle);
    assign period_synced    = period_synced_q;
    assign direction_synced = direction_synced_q;
    assign stopped_synced   = stopped_synced_q;
    assign delta_synced     = delta_synced_q;

endmodule

// File: tb/tb_encoder_velocity.sv
// Directed bench for encoder_velocity: cycle-level reference model plus
// hand-computed checkpoints.
module tb_encoder_velocity;
    import encoder_velocity_pkg::*;

    localparam int unsigned W = 32;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] counter = '0;
    logic         pwm_carrier_low = 1'b0;
    logic         pwm_carrier_high = 1'b0;
    logic [W-1:0] timeout_cycles = '0;
    logic [W-1:0] period, period_synced, delta_synced;
    logic         direction, stopped, direction_synced, stopped_synced;

    int n_checks = 0;
    int n_fail = 0;

    encoder_velocity #(
        .W (W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .counter          (counter),
        .pwm_carrier_low  (pwm_carrier_low),
        .pwm_carrier_high (pwm_carrier_high),
        .timeout_cycles   (timeout_cycles),
        .period           (period),
        .direction        (direction),
        .stopped          (stopped),
        .period_synced    (period_synced),
        .direction_synced (direction_synced),
        .stopped_synced   (stopped_synced),
        .delta_synced     (delta_synced)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the clk index of the last step rather than a timer.
    typedef struct {
        int           mode;      // 0 idle, 1 first step seen, 2 period valid
        logic [W-1:0] prev;
        logic [W-1:0] last_sync;
        logic [W-1:0] per;
        logic [W-1:0] per_s;
        logic [W-1:0] delta;
        logic         dir;
        logic         dir_s;
        logic         stop_s;
        bit           have;
        longint       last_step;
        longint       cyc;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.prev = '0; r.last_sync = '0; r.per = '1; r.per_s = '1;
        r.delta = '0; r.dir = 1'b1; r.dir_s = 1'b1; r.stop_s = 1'b1;
        r.have = 1'b0; r.last_step = 0; r.cyc = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, logic [W-1:0] cnt, logic sync,
                                          logic [W-1:0] tmo);
        model_t       n;
        longint       gap;
        logic [W-1:0] diff;
        bit           sdir;
        n = cur;
        n.cyc = cur.cyc + 1;
        if (sync) begin
            n.per_s     = cur.per;
            n.dir_s     = cur.dir;
            n.stop_s    = (cur.mode == 0);
            n.delta     = cnt - cur.last_sync;
            n.last_sync = cnt;
        end
        gap = MAXV;
        if (cur.have) gap = n.cyc - cur.last_step;
        if (gap > MAXV) gap = MAXV;
        diff = cnt - cur.prev;
        sdir = !diff[W-1];
        if (cnt != cur.prev) begin
            n.have = 1'b1;
            n.last_step = n.cyc;
            if (cur.mode == 0 || sdir != cur.dir) begin
                n.mode = 1; n.dir = sdir; n.per = '1;
            end else begin
                n.mode = 2; n.per = gap[W-1:0];
            end
        end else if (cur.mode != 0 && tmo != 0 && gap >= longint'(tmo)) begin
            n.mode = 0; n.per = '1;
        end
        n.prev = cnt;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, counter, pwm_carrier_low | pwm_carrier_high,
                                    timeout_cycles);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("period", period, m.per);
        check("direction", direction, m.dir);
        check("stopped", stopped, m.mode == 0);
        check("period_synced", period_synced, m.per_s);
        check("direction_synced", direction_synced, m.dir_s);
        check("stopped_synced", stopped_synced, m.stop_s);
        check("delta_synced", delta_synced, m.delta);
    end

    task automatic do_reset(input logic [W-1:0] cnt_init, input logic [W-1:0] tmo);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        counter = cnt_init;
        timeout_cycles = tmo;
        pwm_carrier_low = 1'b0;
        pwm_carrier_high = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Iteration c drives clk c; checks after its negedge see edge c+1.
    initial begin
        // Idle after reset, two strobes with no motion.
        do_reset(32'd0, 32'd0);
        for (int c = 0; c < 100; c++) begin
            pwm_carrier_low = (c == 0);
            pwm_carrier_high = (c == 50);
            @(negedge clk);
            if (c == 99) begin
                check("t1_stopped", stopped, 1);
                check("t1_period", period, PERIOD_UNKNOWN);
                check("t1_delta", delta_synced, 0);
                check("t1_period_synced", period_synced, PERIOD_UNKNOWN);
            end
        end
        pwm_carrier_low = 1'b0;
        pwm_carrier_high = 1'b0;

        // Increments at clk 10, 60, 110.
        do_reset(32'd0, 32'd0);
        for (int c = 0; c < 130; c++) begin
            counter = (c < 10) ? 32'd0 : (c < 60) ? 32'd1 : (c < 110) ? 32'd2 : 32'd3;
            @(negedge clk);
            if (c == 9)   check("t2_stopped_pre", stopped, 1);
            if (c == 59)  check("t2_period_first", period, PERIOD_UNKNOWN);
            if (c == 60) begin
                check("t2_period_e61", period, 50);
                check("t2_dir_e61", direction, 1);
                check("t2_running_e61", stopped, 0);
            end
            if (c == 110) check("t2_period_e111", period, 50);
        end

        // Wrap 0xFFFFFFFF -> 0 is an increment.
        do_reset(32'hFFFF_FFFF, 32'd0);
        for (int c = 0; c < 50; c++) begin
            counter = (c < 10) ? 32'hFFFF_FFFF : (c < 30) ? 32'd0 : 32'd1;
            @(negedge clk);
            if (c == 0)  check("t3_dir_from_reset", direction, 0);
            if (c == 10) check("t3_period_reversal", period, PERIOD_UNKNOWN);
            if (c == 30) begin
                check("t3_period_wrap", period, 20);
                check("t3_dir_wrap", direction, 1);
            end
        end

        // Reversal 6 -> 5 drops back to one-step state.
        do_reset(32'd5, 32'd0);
        for (int c = 0; c < 60; c++) begin
            counter = (c < 10) ? 32'd5 : (c < 40) ? 32'd6 : 32'd5;
            @(negedge clk);
            if (c == 10) check("t4_period_run", period, 10);
            if (c == 40) begin
                check("t4_dir_rev", direction, 0);
                check("t4_period_rev", period, PERIOD_UNKNOWN);
                check("t4_not_stopped", stopped, 0);
            end
        end

        // Timeout of 100 after a single step.
        do_reset(32'd0, 32'd100);
        for (int c = 0; c < 150; c++) begin
            counter = (c < 10) ? 32'd0 : 32'd1;
            @(negedge clk);
            if (c == 109) check("t5_not_yet_stopped", stopped, 0);
            if (c == 110) check("t5_stopped_e111", stopped, 1);
        end

        // Timeout disabled.
        do_reset(32'd0, 32'd0);
        for (int c = 0; c < 400; c++) begin
            counter = (c < 10) ? 32'd0 : 32'd1;
            @(negedge clk);
        end
        check("t5b_never_stopped", stopped, 0);

        // Step arriving exactly at the timeout wins; next timeout then fires.
        do_reset(32'd0, 32'd20);
        for (int c = 0; c < 70; c++) begin
            counter = (c < 10) ? 32'd0 : (c < 30) ? 32'd1 : 32'd2;
            @(negedge clk);
            if (c == 30) begin
                check("t5c_period", period, 20);
                check("t5c_step_wins", stopped, 0);
            end
            if (c == 49) check("t5c_pre_timeout", stopped, 0);
            if (c == 50) check("t5c_timeout", stopped, 1);
        end

        // Strobes at clk 0 and 1000, 37 steps between, last step with the strobe.
        do_reset(32'd0, 32'd0);
        for (int c = 0; c < 1050; c++) begin
            int k;
            k = (c < 100) ? 0 : ((c - 100) / 20 + 1);
            if (k > 36) k = 36;
            counter = 32'(k) + ((c >= 1000) ? 32'd1 : 32'd0);
            pwm_carrier_low = (c == 0) || (c == 1000);
            pwm_carrier_high = (c == 1000);
            @(negedge clk);
            if (c == 1000) begin
                check("t6_delta", delta_synced, 37);
                check("t6_period_synced", period_synced, 20);
                check("t6_period_now", period, 200);
                check("t6_dir_synced", direction_synced, 1);
                check("t6_stopped_synced", stopped_synced, 0);
            end
            if (c == 1049) check("t6_delta_hold", delta_synced, 37);
        end
        pwm_carrier_low = 1'b0;
        pwm_carrier_high = 1'b0;

        // Mid-operation asynchronous reset.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_period", period, PERIOD_UNKNOWN);
        check("rst_stopped", stopped, 1);
        check("rst_delta", delta_synced, 0);
        check("rst_period_synced", period_synced, PERIOD_UNKNOWN);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
